// File: rtl/matrix_sequencer.sv
// matrix_sequencer: walks the elements of run-time sized (2..5) matrices,
// fetching operands from two external row-major memories, feeding an external
// combinational ALU and emitting row-major result writes. multM accumulates
// n partial products per output element in an 8-bit wrapping accumulator.
module matrix_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [2:0] size,
    output logic [4:0] a_idx,
    input  logic [7:0] a_data,
    output logic [4:0] b_idx,
    input  logic [7:0] b_data,
    output logic [2:0] alu_op,
    output logic [2:0] alu_s,
    output logic [7:0] alu_r1,
    output logic [7:0] alu_r2,
    input  logic [7:0] alu_res,
    output logic       res_we,
    output logic [4:0] res_idx,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] OP_ADDM   = 3'd0;
    localparam logic [2:0] OP_SUBM   = 3'd1;
    localparam logic [2:0] OP_MULTM  = 3'd2;
    localparam logic [2:0] OP_MULTMR = 3'd3;
    localparam logic [2:0] OP_DETM   = 3'd4;
    localparam logic [2:0] OP_TRANSM = 3'd5;
    localparam logic [2:0] OP_OPPM   = 3'd6;
    localparam logic [2:0] OP_RST    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] n_q, n_d;
    logic [2:0] i_q, i_d;
    logic [2:0] j_q, j_d;
    logic [2:0] k_q, k_d;
    logic [7:0] acc_q, acc_d;
    logic       err_q, err_d;

    logic       is_mult_s;
    logic       k_last_s;
    logic       j_last_s;
    logic       i_last_s;
    logic       bad_req_s;
    logic [7:0] sum_s;

    // Row-major index r*n+c; fits in 5 bits for n <= 5.
    function automatic logic [4:0] rc_idx(input logic [2:0] r, input logic [2:0] c,
                                          input logic [2:0] n);
        logic [4:0] prod;
        prod   = {2'b00, r} * {2'b00, n};
        rc_idx = prod + {2'b00, c};
    endfunction

    // Loop-bound flags and the accumulator sum; element-wise ops have a single k step.
    always_comb begin
        is_mult_s = (op_q == OP_MULTM);
        k_last_s  = (!is_mult_s) || (k_q == (n_q - 3'd1));
        j_last_s  = (j_q == (n_q - 3'd1));
        i_last_s  = (i_q == (n_q - 3'd1));
        bad_req_s = (size < 3'd2) || (size > 3'd5) || (op == OP_DETM) || (op == OP_RST);
        if (k_q == 3'd0) begin
            sum_s = alu_res;
        end else begin
            sum_s = acc_q + alu_res;
        end
    end

    // State register and loop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            n_q     <= 3'd0;
            i_q     <= 3'd0;
            j_q     <= 3'd0;
            k_q     <= 3'd0;
            acc_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            n_q     <= n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

    // Next-state: accept/reject in IDLE, alternate READ/EXEC, step k then j then i.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        n_d     = n_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    n_d   = size;
                    i_d   = 3'd0;
                    j_d   = 3'd0;
                    k_d   = 3'd0;
                    acc_d = 8'd0;
                    if (bad_req_s) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                acc_d = sum_s;
                if (!k_last_s) begin
                    k_d     = k_q + 3'd1;
                    state_d = S_READ;
                end else begin
                    k_d = 3'd0;
                    if (!j_last_s) begin
                        j_d     = j_q + 3'd1;
                        state_d = S_READ;
                    end else begin
                        j_d = 3'd0;
                        if (!i_last_s) begin
                            i_d     = i_q + 3'd1;
                            state_d = S_READ;
                        end else begin
                            i_d     = 3'd0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: addresses in READ, ALU operands and result write in EXEC, zero elsewhere.
    always_comb begin
        a_idx    = 5'd0;
        b_idx    = 5'd0;
        alu_r1   = 8'd0;
        alu_r2   = 8'd0;
        res_we   = 1'b0;
        res_idx  = 5'd0;
        res_data = 8'd0;
        alu_op   = op_q;
        alu_s    = n_q;
        busy     = (state_q == S_READ) || (state_q == S_EXEC);
        done     = (state_q == S_DONE);
        err      = (state_q == S_DONE) && err_q;
        case (state_q)
            S_READ: begin
                if (is_mult_s) begin
                    a_idx = rc_idx(i_q, k_q, n_q);
                    b_idx = rc_idx(k_q, j_q, n_q);
                end else begin
                    a_idx = rc_idx(i_q, j_q, n_q);
                    if (op_q == OP_MULTMR) begin
                        b_idx = 5'd0;
                    end else begin
                        b_idx = rc_idx(i_q, j_q, n_q);
                    end
                end
            end
            S_EXEC: begin
                alu_r1 = a_data;
                case (op_q)
                    OP_ADDM, OP_SUBM, OP_MULTM, OP_MULTMR: alu_r2 = b_data;
                    OP_TRANSM:                             alu_r2 = 8'h01;
                    OP_OPPM:                               alu_r2 = 8'hFF;
                    default:                               alu_r2 = 8'h00;
                endcase
                if (k_last_s) begin
                    res_we   = 1'b1;
                    res_data = sum_s;
                    if (op_q == OP_TRANSM) begin
                        res_idx = rc_idx(j_q, i_q, n_q);
                    end else begin
                        res_idx = rc_idx(i_q, j_q, n_q);
                    end
                end else begin
                    res_we = 1'b0;
                end
            end
            default: begin
                a_idx = 5'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_sequencer.sv
// Self-checking bench for matrix_sequencer: operand memories and ALU are
// modelled here; expected results come from plain matrix arithmetic.
module tb_matrix_sequencer;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [2:0] op, size;
    logic [4:0] a_idx, b_idx, res_idx;
    logic [7:0] a_data, b_data, alu_r1, alu_r2, alu_res, res_data;
    logic [2:0] alu_op, alu_s;
    logic       res_we, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_a [0:24];
    logic [7:0] mem_b [0:24];

    logic       exp_we   [0:299];
    logic [4:0] exp_idx  [0:299];
    logic [7:0] exp_data [0:299];
    logic       exp_busy [0:299];
    logic       exp_done [0:299];
    logic       exp_err  [0:299];
    int         exp_last;

    matrix_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .size(size),
        .a_idx(a_idx), .a_data(a_data), .b_idx(b_idx), .b_data(b_data),
        .alu_op(alu_op), .alu_s(alu_s), .alu_r1(alu_r1), .alu_r2(alu_r2),
        .alu_res(alu_res), .res_we(res_we), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        a_data <= (a_idx < 5'd25) ? mem_a[a_idx] : 8'h00;
        b_data <= (b_idx < 5'd25) ? mem_b[b_idx] : 8'h00;
    end

    // Combinational ALU.
    always_comb begin
        case (alu_op)
            3'd0:    alu_res = alu_r1 + alu_r2;
            3'd1:    alu_res = alu_r1 - alu_r2;
            default: alu_res = 8'(alu_r1 * alu_r2);
        endcase
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Expected per-cycle behaviour from matrix arithmetic and the cycle formulas.
    task automatic build_expect(input logic [2:0] o, input logic [2:0] n);
        int nn, total, sum, c, v, a, bb, idx;
        nn = int'(n);
        for (int x = 0; x < 300; x++) begin
            exp_we[x] = 1'b0; exp_idx[x] = 5'd0; exp_data[x] = 8'd0;
            exp_busy[x] = 1'b0; exp_done[x] = 1'b0; exp_err[x] = 1'b0;
        end
        if (nn < 2 || nn > 5 || o == 3'd4 || o == 3'd7) begin
            exp_done[1] = 1'b1;
            exp_err[1]  = 1'b1;
            exp_last    = 2;
        end else if (o == 3'd2) begin
            total = 2 * nn * nn * nn;
            for (int i = 0; i < nn; i++) begin
                for (int j = 0; j < nn; j++) begin
                    sum = 0;
                    for (int k = 0; k < nn; k++) begin
                        sum += int'(mem_a[i*nn+k]) * int'(mem_b[k*nn+j]);
                    end
                    c = 2 * nn * (i*nn + j + 1);
                    exp_we[c]   = 1'b1;
                    exp_idx[c]  = 5'(i*nn + j);
                    exp_data[c] = 8'(sum);
                end
            end
            for (int x = 1; x <= total; x++) exp_busy[x] = 1'b1;
            exp_done[total+1] = 1'b1;
            exp_last = total + 2;
        end else begin
            total = 2 * nn * nn;
            for (int e = 0; e < nn*nn; e++) begin
                a  = int'(mem_a[e]);
                bb = int'(mem_b[e]);
                case (o)
                    3'd0:    v = a + bb;
                    3'd1:    v = a - bb;
                    3'd3:    v = a * int'(mem_b[0]);
                    3'd5:    v = a;
                    default: v = 0 - a;
                endcase
                idx = (o == 3'd5) ? ((e % nn) * nn + e / nn) : e;
                exp_we[2*e+2]   = 1'b1;
                exp_idx[2*e+2]  = 5'(idx);
                exp_data[2*e+2] = 8'(v);
            end
            for (int x = 1; x <= total; x++) exp_busy[x] = 1'b1;
            exp_done[total+1] = 1'b1;
            exp_last = total + 2;
        end
    endtask

    task automatic compare(input int c, input logic [2:0] o, input logic [2:0] n);
        chk($sformatf("busy c%0d", c), int'(busy), int'(exp_busy[c]));
        chk($sformatf("done c%0d", c), int'(done), int'(exp_done[c]));
        chk($sformatf("err c%0d", c), int'(err), int'(exp_err[c]));
        chk($sformatf("res_we c%0d", c), int'(res_we), int'(exp_we[c]));
        if (exp_we[c]) begin
            chk($sformatf("res_idx c%0d", c), int'(res_idx), int'(exp_idx[c]));
            chk($sformatf("res_data c%0d", c), int'(res_data), int'(exp_data[c]));
        end
        chk($sformatf("alu_op c%0d", c), int'(alu_op), int'(o));
        chk($sformatf("alu_s c%0d", c), int'(alu_s), int'(n));
        if (!exp_busy[c]) begin
            chk($sformatf("idle_zero c%0d", c),
                int'(a_idx) + int'(b_idx) + int'(alu_r1) + int'(alu_r2) + int'(res_data), 0);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [2:0] n, input bit hold);
        build_expect(o, n);
        op    = o;
        size  = n;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= exp_last; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            compare(c, o, n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " outputs"},
            int'(a_idx) + int'(b_idx) + int'(alu_op) + int'(alu_s) + int'(alu_r1) +
            int'(alu_r2) + int'(res_we) + int'(res_idx) + int'(res_data) +
            int'(busy) + int'(done) + int'(err), 0);
    endtask

    task automatic find_write(input int idx, output int data);
        data = -1;
        for (int x = 0; x < 300; x++) begin
            if (exp_we[x] && int'(exp_idx[x]) == idx) data = int'(exp_data[x]);
        end
    endtask

    initial begin
        int d, seen_we, seen_done, seen_busy;
        rst = 1'b1; start = 1'b0; op = 3'd0; size = 3'd0;
        for (int x = 0; x < 25; x++) begin mem_a[x] = 8'd0; mem_b[x] = 8'd0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // addM n=2
        for (int x = 0; x < 4; x++) begin
            mem_a[x] = 8'(x + 1);
            mem_b[x] = 8'(10 * (x + 1));
        end
        build_expect(3'd0, 3'd2);
        chk("pin add c2", int'(exp_data[2]), 11);
        chk("pin add c8", int'(exp_data[8]), 44);
        chk("pin add done9", int'(exp_done[9]), 1);
        run_op(3'd0, 3'd2, 1'b0);

        // multM n=2
        for (int x = 0; x < 4; x++) mem_b[x] = 8'(x + 5);
        build_expect(3'd2, 3'd2);
        chk("pin mult c4", int'(exp_data[4]), 19);
        chk("pin mult c16", int'(exp_data[16]), 50);
        chk("pin mult done17", int'(exp_done[17]), 1);
        run_op(3'd2, 3'd2, 1'b0);
        for (int x = 0; x < 4; x++) begin mem_a[x] = 8'd10; mem_b[x] = 8'd10; end
        build_expect(3'd2, 3'd2);
        chk("pin mult wrap", int'(exp_data[8]), 200);
        run_op(3'd2, 3'd2, 1'b0);

        // transM n=3
        for (int x = 0; x < 9; x++) mem_a[x] = 8'(x);
        build_expect(3'd5, 3'd3);
        find_write(1, d); chk("pin trans idx1", d, 3);
        find_write(5, d); chk("pin trans idx5", d, 7);
        find_write(2, d); chk("pin trans idx2", d, 6);
        chk("pin trans done19", int'(exp_done[19]), 1);
        run_op(3'd5, 3'd3, 1'b0);

        // rejections
        run_op(3'd0, 3'd6, 1'b0);
        run_op(3'd4, 3'd3, 1'b0);

        // reset mid-operation
        for (int x = 0; x < 9; x++) begin mem_a[x] = 8'(x * 3); mem_b[x] = 8'(x + 7); end
        build_expect(3'd0, 3'd3);
        op = 3'd0; size = 3'd3; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            compare(c, 3'd0, 3'd3);
        end
        rst = 1'b1;
        #1;
        check_all_zero("rst async");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst held");
        rst = 1'b0;
        seen_we = 0; seen_done = 0; seen_busy = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            seen_we   += int'(res_we);
            seen_done += int'(done) + int'(err);
            seen_busy += int'(busy);
        end
        chk("after rst writes", seen_we, 0);
        chk("after rst done", seen_done, 0);
        chk("after rst busy", seen_busy, 0);
        run_op(3'd0, 3'd3, 1'b0);

        // start held high: second op accepted in the IDLE cycle
        for (int x = 0; x < 4; x++) begin mem_a[x] = 8'(x + 1); mem_b[x] = 8'(10 * (x + 1)); end
        run_op(3'd0, 3'd2, 1'b1);
        run_op(3'd0, 3'd2, 1'b0);

        // randomized operations
        for (int t = 0; t < 40; t++) begin
            logic [2:0] ro, rn;
            ro = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rn = 3'($urandom_range(0, 7));
            else rn = 3'($urandom_range(2, 5));
            for (int x = 0; x < 25; x++) begin
                mem_a[x] = 8'($urandom);
                mem_b[x] = 8'($urandom);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(ro, rn, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_sequencer.md
MATRIX_SEQUENCER -- requirements
Module: matrix_sequencer

Interface
REQ-001 Parameter: none; matrix dimension is run-time (size 2..5, max 25 elements); data width fixed at 8-bit signed.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin operation; sampled only in IDLE.
REQ-006 op  in  3  operation code: 000 addM, 001 subM, 010 multM, 011 multMR, 100 detM, 101 transM, 110 oppM, 111 rst.
REQ-007 size  in  3  matrix dimension n.
REQ-008 a_idx  out  5  read index into operand matrix A, row-major (row*n+col).
REQ-009 a_data  in  8  A element; valid the cycle after a_idx is presented.
REQ-010 b_idx  out  5  read index into operand matrix B, row-major.
REQ-011 b_data  in  8  B element; valid the cycle after b_idx is presented.
REQ-012 alu_op  out  3  latched op to the ALU.
REQ-013 alu_s  out  3  latched n to the ALU.
REQ-014 alu_r1, alu_r2  out  8 each  ALU operands.
REQ-015 alu_res  in  8  combinational ALU result for the current alu_r1/alu_r2.
REQ-016 res_we  out  1  result write strobe.
REQ-017 res_idx  out  5  result index, row-major.
REQ-018 res_data  out  8  result value.
REQ-019 busy  out  1  high while sequencing; done  out  1  one-cycle completion pulse; err  out  1  one-cycle rejection pulse.

Function
REQ-020 States: IDLE, READ, EXEC, DONE. At the accepting edge (cycle 0), op and size are latched into alu_op and alu_s; they hold until the next accepted start.
REQ-021 start is accepted in IDLE only; start in any other state is ignored.
REQ-022 Rejection: if size is not in 2..5, or op is detM or rst, then in cycle 1 err=1 and done=1, there are no reads and no res_we, and the block returns to IDLE in cycle 2.
REQ-023 Element-wise ops (addM, subM, multMR, transM, oppM), N=n*n elements, element e in 0..N-1:
  - READ in cycle 2e+1, EXEC in cycle 2e+2.
  - busy=1 in cycles 1..2N; done=1 in cycle 2N+1; IDLE from cycle 2N+2.
REQ-024 READ: a_idx=e, b_idx=e; for multMR, b_idx=0 (scalar is B[0]).
REQ-025 EXEC: alu_r1=a_data; alu_r2 is:
  - b_data for addM, subM, multMR;
  - 8'h01 for transM;
  - 8'hFF (-1) for oppM.
  In the same cycle res_we=1 and res_data=alu_res.
REQ-026 res_idx=e for all element-wise ops except transM, where res_idx=col*n+row with e=row*n+col.
REQ-027 multM: for each output (i,j), k = 0..n-1:
  - READ: a_idx=i*n+k, b_idx=k*n+j.
  - EXEC: alu_r1=a_data, alu_r2=b_data.
  - 8-bit accumulator: cleared at k=0, accumulates alu_res, wraps modulo 256 with no saturation.
REQ-028 multM write: res_we=1 only on the EXEC with k=n-1, with res_data=acc+alu_res (wrapped) and res_idx=i*n+j. Outputs are ordered row-major. Total 2n^3 cycles; done in cycle 2n^3+1.
REQ-029 res_we is asserted only in EXEC, at most once per result index per operation.
REQ-030 Outside EXEC, alu_r1, alu_r2 and res_data are 0; outside READ, a_idx and b_idx are 0.
REQ-031 done and err each pulse exactly one cycle; busy=0 whenever done=1.

Reset
REQ-032 While rst=1, all outputs are 0 immediately (asynchronous), including alu_op and alu_s. The state is IDLE and the accumulator and latched op/size are cleared.
REQ-033 rst asserted mid-operation aborts the operation. No res_we, done or err follows, and a start after rst deasserts begins a fresh operation.

Verification
REQ-034 addM, n=2, A=[1,2,3,4], B=[10,20,30,40] -> res_we in cycles 2,4,6,8 writing idx0..3 = 11,22,33,44; done in cycle 9.
REQ-035 multM, n=2, A=[1,2,3,4], B=[5,6,7,8] -> writes 19,22,43,50 to idx0..3 in cycles 4,8,12,16; done in cycle 17. With A and B all 10 -> every result is 8'hC8 (-56) due to wrap.
REQ-036 transM, n=3, A[e]=e -> res_idx 1 receives 3, res_idx 5 receives 7, res_idx 2 receives 6; done in cycle 19.
REQ-037 start with size=6, or with op=detM -> err=1 and done=1 in cycle 1, res_we never asserted, busy never asserted.
REQ-038 addM n=3 with rst pulsed in cycle 5 -> all outputs 0 during rst, no further writes and no done. A restart then completes normally with done in cycle 19 of the new operation.
REQ-039 start held high throughout an addM n=2 operation -> exactly 4 writes and one done. The next operation is accepted in cycle 10 (IDLE).
